reg_bus_arbiter: RTL and testbench
==================================

// Module: reg_bus_arbiter
// PURPOSE
//   Shares the single peripheral register bus (index/read/write/write_value/read_value) between two
//   requesters: m0 = ulisp core, m1 = debug bridge. Round-robin arbitration, one transaction in flight,
//   registered bus strobes, read data captured after a fixed peripheral latency, one-cycle ack per requester.
//   Sits between the requesters and the LED/7-segment/button register block in the top level.
// PARAMETERS
//   INDEX_WIDTH   7   register index width
//   DATA_WIDTH    16  register data width
//   READ_LATENCY  1   cycles from register_read strobe to valid register_read_value; legal 1..4
// PORTS
//   clk                   in   1    sole clock
//   reset_n               in   1    asynchronous, active-low reset
//   m0_req / m1_req       in   1    request; held with command fields stable until matching ack
//   mN_index              in   IW   target register index
//   mN_read / mN_write    in   1    transaction type; write wins if both high
//   mN_write_value        in   DW   write data
//   mN_ack                out  1    one-cycle completion pulse
//   mN_read_data          out  DW  captured read data; valid in ack cycle, held until next read ack to mN
//   register_index        out  IW   bus index (registered)
//   register_read         out  1    bus read strobe, exactly one cycle per read
//   register_write        out  1    bus write strobe, exactly one cycle per write
//   register_write_value  out  DW   bus write data (registered)
//   register_read_value   in   DW   peripheral read data
//   owner                 out  1    requester of current/last transaction (debug)
// BEHAVIOUR
//   - Reset: all outputs 0, state IDLE, last_served = m1 (so m0 wins the first tie); in-flight op dropped, no ack.
//   - States: IDLE -> ISSUE -> (write) DONE -> IDLE; (read) ISSUE -> WAIT -> DONE -> IDLE.
//   - IDLE: if any req, grant one: sole requester, or on tie the one != last_served. Latch index, type,
//     write value; set owner, last_served; -> ISSUE. No req: stay.
//   - A req with neither read nor write: granted, no bus strobe, acked as a write (ISSUE -> DONE).
//   - ISSUE (1 cycle): register_write or register_read = 1 with register_index/write_value from latches.
//   - WAIT: counter loads READ_LATENCY; capture register_read_value into owner's read_data on the cycle
//     READ_LATENCY after the strobe cycle; earlier bus values ignored; -> DONE.
//   - DONE (1 cycle): owner's ack = 1; other ack stays 0. Requester drops or replaces req the cycle after ack.
//   - Latency from req sampled in IDLE: write ack at +2 cycles; read ack at +2+READ_LATENCY.
//   - Back-to-back: at most one transaction per 3 (write) / 3+READ_LATENCY (read) cycles; no pipelining.
//   - register_index/write_value change only on grant; strobes 0 outside ISSUE; never both strobes high.
//   - A req arriving mid-transaction waits; req dropped before ack = protocol violation (assert in sim).
// STRUCTURE
//   - Shared package reg_bus_pkg: state enum (IDLE/ISSUE/WAIT/DONE), INDEX_WIDTH/DATA_WIDTH defaults,
//     register index constants (LED=1, DIGIT0..3=2..5, BUTTONS=6).
//   - Sub-module rr_arbiter2: 2-way round-robin pick from {req1,req0,last_served} -> grant; combinational
//     plus last_served register. Everything else (FSM, latches, latency counter) in this module.
// TESTING
//   1. reset_n low mid-run, then high -> all outputs 0, no ack; first request served normally.
//   2. m0 write idx 1 value 16'h00A5 -> register_write high 1 cycle, index 1, value 16'h00A5; m0_ack at +2; m1_ack 0.
//   3. m1 read idx 6, model returns 16'h0009 at latency 1 -> register_read 1 cycle; m1_ack at +3; m1_read_data 16'h0009.
//   4. both reqs held continuously from reset, 4 transactions -> owner sequence m0,m1,m0,m1; acks never overlap.
//   5. READ_LATENCY=3, model drives 16'hDEAD then 16'hBEEF on strobe+3 -> ack at +5, read_data 16'hBEEF.
//   6. reset_n pulsed low in WAIT of an m0 read -> no m0_ack, strobes 0, m0_read_data 0; re-issued read completes.

Source files
------------

// File: rtl/reg_bus_pkg.sv
// Shared types and constants for the peripheral register bus: FSM states, op decode,
// default widths and the register map of the LED/7-segment/button block.
package reg_bus_pkg;

    localparam int REG_INDEX_W = 7;
    localparam int REG_DATA_W  = 16;

    localparam logic [REG_INDEX_W-1:0] REG_LED     = 7'd1;
    localparam logic [REG_INDEX_W-1:0] REG_DIGIT0  = 7'd2;
    localparam logic [REG_INDEX_W-1:0] REG_DIGIT1  = 7'd3;
    localparam logic [REG_INDEX_W-1:0] REG_DIGIT2  = 7'd4;
    localparam logic [REG_INDEX_W-1:0] REG_DIGIT3  = 7'd5;
    localparam logic [REG_INDEX_W-1:0] REG_BUTTONS = 7'd6;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;
    typedef enum logic [1:0] {OP_NONE, OP_READ, OP_WRITE} op_e;

    // Write wins when both type bits are set; neither set is a bus-silent op acked like a write.
    function automatic op_e decode_op(input logic wr, input logic rd);
        if (wr) return OP_WRITE;
        if (rd) return OP_READ;
        return OP_NONE;
    endfunction

endpackage

// File: rtl/reg_bus_arbiter_if.sv
// Requester-side and register-bus-side signals of the arbiter. The arbiter uses the slave
// modport; requesters and the peripheral model drive through master.
import reg_bus_pkg::*;

interface reg_bus_arbiter_if #(
    parameter int IW = REG_INDEX_W,
    parameter int DW = REG_DATA_W
) ();
    logic          m0_req, m0_read, m0_write, m0_ack;
    logic [IW-1:0] m0_index;
    logic [DW-1:0] m0_write_value, m0_read_data;

    logic          m1_req, m1_read, m1_write, m1_ack;
    logic [IW-1:0] m1_index;
    logic [DW-1:0] m1_write_value, m1_read_data;

    logic [IW-1:0] register_index;
    logic          register_read, register_write;
    logic [DW-1:0] register_write_value, register_read_value;
    logic          owner;

    modport slave (
        input  m0_req, m0_read, m0_write, m0_index, m0_write_value,
        output m0_ack, m0_read_data,
        input  m1_req, m1_read, m1_write, m1_index, m1_write_value,
        output m1_ack, m1_read_data,
        output register_index, register_read, register_write, register_write_value,
        input  register_read_value,
        output owner
    );

    modport master (
        output m0_req, m0_read, m0_write, m0_index, m0_write_value,
        input  m0_ack, m0_read_data,
        output m1_req, m1_read, m1_write, m1_index, m1_write_value,
        input  m1_ack, m1_read_data,
        input  register_index, register_read, register_write, register_write_value,
        output register_read_value,
        input  owner
    );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the one not served last.
// last_served resets to requester 1 so requester 0 wins the first tie.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic       grant
);
    logic last_q, last_d;

    always_comb begin
        grant  = (req == 2'b11) ? ~last_q : req[1];
        last_d = advance ? grant : last_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) last_q <= 1'b1;
        else          last_q <= last_d;
    end
endmodule

// File: rtl/reg_bus_arbiter.sv
// Shares the peripheral register bus between the ulisp core (m0) and the debug bridge (m1):
// one transaction at a time, registered strobes, read data captured READ_LATENCY after the strobe.
import reg_bus_pkg::*;

module reg_bus_arbiter #(
    parameter int INDEX_WIDTH  = REG_INDEX_W,
    parameter int DATA_WIDTH   = REG_DATA_W,
    parameter int READ_LATENCY = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    reg_bus_arbiter_if.slave   bus
);
    localparam int CW = 3;

    state_e                           state_q, state_d;
    op_e                              op_q, op_d;
    logic                             owner_q, owner_d;
    logic [INDEX_WIDTH-1:0]           index_q, index_d;
    logic [DATA_WIDTH-1:0]            wdata_q, wdata_d;
    logic                             rd_stb_q, rd_stb_d;
    logic                             wr_stb_q, wr_stb_d;
    logic [CW-1:0]                    cnt_q, cnt_d;
    logic [1:0][DATA_WIDTH-1:0]       rdata_q, rdata_d;

    logic [1:0]                       req, rd, wr;
    logic [1:0][INDEX_WIDTH-1:0]      idx;
    logic [1:0][DATA_WIDTH-1:0]       wv;
    logic                             take, gnt;

    assign req  = {bus.m1_req,   bus.m0_req};
    assign rd   = {bus.m1_read,  bus.m0_read};
    assign wr   = {bus.m1_write, bus.m0_write};
    assign idx  = {bus.m1_index, bus.m0_index};
    assign wv   = {bus.m1_write_value, bus.m0_write_value};
    assign take = (state_q == IDLE) && (|req);

    rr_arbiter2 u_rr (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .advance (take),
        .grant   (gnt)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        owner_d  = owner_q;
        index_d  = index_q;
        wdata_d  = wdata_q;
        rd_stb_d = 1'b0;
        wr_stb_d = 1'b0;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        case (state_q)
            IDLE: begin
                if (take) begin
                    owner_d  = gnt;
                    index_d  = idx[gnt];
                    wdata_d  = wv[gnt];
                    op_d     = decode_op(wr[gnt], rd[gnt]);
                    // Strobes are set here so they are flop outputs during ISSUE.
                    wr_stb_d = (op_d == OP_WRITE);
                    rd_stb_d = (op_d == OP_READ);
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                if (op_q == OP_READ) begin
                    cnt_d   = CW'(READ_LATENCY);
                    state_d = WAIT;
                end else begin
                    state_d = DONE;
                end
            end
            WAIT: begin
                // Last WAIT cycle is exactly READ_LATENCY cycles after the strobe cycle.
                if (cnt_q == CW'(1)) begin
                    rdata_d[owner_q] = bus.register_read_value;
                    state_d          = DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            op_q     <= OP_NONE;
            owner_q  <= 1'b0;
            index_q  <= '0;
            wdata_q  <= '0;
            rd_stb_q <= 1'b0;
            wr_stb_q <= 1'b0;
            cnt_q    <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            owner_q  <= owner_d;
            index_q  <= index_d;
            wdata_q  <= wdata_d;
            rd_stb_q <= rd_stb_d;
            wr_stb_q <= wr_stb_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
        end
    end

    assign bus.register_index       = index_q;
    assign bus.register_write_value = wdata_q;
    assign bus.register_read        = rd_stb_q;
    assign bus.register_write       = wr_stb_q;
    assign bus.owner                = owner_q;
    assign bus.m0_ack               = (state_q == DONE) && !owner_q;
    assign bus.m1_ack               = (state_q == DONE) &&  owner_q;
    assign bus.m0_read_data         = rdata_q[0];
    assign bus.m1_read_data         = rdata_q[1];

    // The granted requester must hold its request until its ack cycle has passed.
    always @(posedge clk) begin
        if (reset_n && state_q != IDLE) assert (req[owner_q]);
    end
endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Directed bench for reg_bus_arbiter: one instance at read latency 1, one at read latency 3.
import reg_bus_pkg::*;

module tb_reg_bus_arbiter;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   passed = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    reg_bus_arbiter_if #(.IW(7), .DW(16)) b  ();
    reg_bus_arbiter_if #(.IW(7), .DW(16)) b3 ();

    reg_bus_arbiter #(.INDEX_WIDTH(7), .DATA_WIDTH(16), .READ_LATENCY(1)) dut (
        .clk(clk), .reset_n(reset_n), .bus(b));
    reg_bus_arbiter #(.INDEX_WIDTH(7), .DATA_WIDTH(16), .READ_LATENCY(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .bus(b3));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic clr_inputs();
        b.m0_req = 0; b.m0_read = 0; b.m0_write = 0; b.m0_index = '0; b.m0_write_value = '0;
        b.m1_req = 0; b.m1_read = 0; b.m1_write = 0; b.m1_index = '0; b.m1_write_value = '0;
        b.register_read_value = '0;
        b3.m0_req = 0; b3.m0_read = 0; b3.m0_write = 0; b3.m0_index = '0; b3.m0_write_value = '0;
        b3.m1_req = 0; b3.m1_read = 0; b3.m1_write = 0; b3.m1_index = '0; b3.m1_write_value = '0;
        b3.register_read_value = '0;
    endtask

    initial begin
        clr_inputs();
        repeat (2) step();
        chk("rst_owner", b.owner, 0);
        chk("rst_rd", b.register_read, 0);
        chk("rst_wr", b.register_write, 0);
        chk("rst_index", b.register_index, 0);
        chk("rst_wval", b.register_write_value, 0);
        chk("rst_acks", {b.m1_ack, b.m0_ack}, 0);
        chk("rst_rdata", {b.m1_read_data, b.m0_read_data}, 0);
        reset_n = 1;

        // m0 write LED <= 0x00A5
        step();
        b.m0_req = 1; b.m0_write = 1; b.m0_index = REG_LED; b.m0_write_value = 16'h00A5;
        step();
        chk("w_strobe", b.register_write, 1);
        chk("w_no_rd", b.register_read, 0);
        chk("w_index", b.register_index, 1);
        chk("w_value", b.register_write_value, 16'h00A5);
        chk("w_early_ack", b.m0_ack, 0);
        step();
        chk("w_strobe_1cyc", b.register_write, 0);
        chk("w_ack", b.m0_ack, 1);
        chk("w_other_ack", b.m1_ack, 0);
        step();
        chk("w_ack_1cyc", b.m0_ack, 0);
        b.m0_req = 0; b.m0_write = 0;

        // m1 read BUTTONS, peripheral answers 0x0009 one cycle after the strobe
        b.m1_req = 1; b.m1_read = 1; b.m1_index = REG_BUTTONS;
        step();
        chk("r_strobe", b.register_read, 1);
        chk("r_no_wr", b.register_write, 0);
        chk("r_index", b.register_index, 6);
        chk("r_owner", b.owner, 1);
        b.register_read_value = 16'hFFFF;
        step();
        chk("r_strobe_1cyc", b.register_read, 0);
        chk("r_early_ack", b.m1_ack, 0);
        b.register_read_value = 16'h0009;
        step();
        chk("r_ack", b.m1_ack, 1);
        chk("r_other_ack", b.m0_ack, 0);
        chk("r_data", b.m1_read_data, 16'h0009);
        chk("r_m0_data", b.m0_read_data, 0);
        step();
        b.m1_req = 0; b.m1_read = 0; b.register_read_value = '0;

        // m0 read DIGIT3 completes, then the repeated read is cut by reset in WAIT
        b.m0_req = 1; b.m0_read = 1; b.m0_index = REG_DIGIT3;
        step();
        chk("rr_strobe", b.register_read, 1);
        chk("rr_index", b.register_index, 5);
        b.register_read_value = 16'h1234;
        step();
        step();
        chk("rr_ack", b.m0_ack, 1);
        chk("rr_data", b.m0_read_data, 16'h1234);
        step();
        b.register_read_value = '0;
        step();
        chk("rr2_strobe", b.register_read, 1);
        step();
        b.register_read_value = 16'h5555;
        reset_n = 0;
        #1;
        chk("rst_wait_ack", b.m0_ack, 0);
        chk("rst_wait_rd", b.register_read, 0);
        chk("rst_wait_wr", b.register_write, 0);
        chk("rst_wait_rdata", b.m0_read_data, 0);
        step();
        chk("rst_wait_noack", b.m0_ack, 0);
        reset_n = 1;
        step();
        chk("reissue_strobe", b.register_read, 1);
        chk("reissue_index", b.register_index, 5);
        b.register_read_value = 16'h7777;
        step();
        step();
        chk("reissue_ack", b.m0_ack, 1);
        chk("reissue_data", b.m0_read_data, 16'h7777);
        step();
        b.m0_req = 0; b.m0_read = 0; b.register_read_value = '0;

        // reset mid-run with both requesters writing continuously
        reset_n = 0;
        b.m0_req = 1; b.m0_write = 1; b.m0_index = REG_DIGIT0; b.m0_write_value = 16'h0011;
        b.m1_req = 1; b.m1_write = 1; b.m1_index = REG_DIGIT1; b.m1_write_value = 16'h0022;
        #1;
        chk("rst2_owner", b.owner, 0);
        chk("rst2_index", b.register_index, 0);
        chk("rst2_m1_rdata", b.m1_read_data, 0);
        chk("rst2_acks", {b.m1_ack, b.m0_ack}, 0);
        step();
        reset_n = 1;
        for (int k = 1; k <= 12; k++) begin
            step();
            chk("rr_no_overlap", b.m0_ack & b.m1_ack, 0);
            if (k % 3 == 1) begin
                chk("rr_owner", b.owner, ((k - 1) / 3) % 2);
                chk("rr_wr", b.register_write, 1);
                chk("rr_idx", b.register_index, (((k - 1) / 3) % 2 == 1) ? 3 : 2);
                chk("rr_wval", b.register_write_value, (((k - 1) / 3) % 2 == 1) ? 16'h0022 : 16'h0011);
            end
            if (k % 3 == 2) begin
                chk("rr_ack_owner", {b.m1_ack, b.m0_ack}, (((k - 2) / 3) % 2 == 1) ? 2 : 1);
            end
        end
        b.m0_req = 0; b.m0_write = 0; b.m1_req = 0; b.m1_write = 0;

        // read latency 3: only the value present at strobe+3 is captured
        step();
        b3.m0_req = 1; b3.m0_read = 1; b3.m0_index = REG_BUTTONS;
        step();
        chk("l3_strobe", b3.register_read, 1);
        step();
        b3.register_read_value = 16'hDEAD;
        chk("l3_ack_c2", b3.m0_ack, 0);
        step();
        chk("l3_ack_c3", b3.m0_ack, 0);
        step();
        b3.register_read_value = 16'hBEEF;
        chk("l3_rd_low", b3.register_read, 0);
        chk("l3_ack_c4", b3.m0_ack, 0);
        step();
        chk("l3_ack", b3.m0_ack, 1);
        chk("l3_other_ack", b3.m1_ack, 0);
        chk("l3_data", b3.m0_read_data, 16'hBEEF);
        step();
        b3.m0_req = 0; b3.m0_read = 0; b3.register_read_value = '0;
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
